hazard_scheduler: RTL
=====================

HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 SHALL have parameters: WARN_TICKS, default 3, warning duration in ticks; FIRE_TICKS, default 2, fire duration in ticks; GAP_TICKS, default 1, idle gap between rounds in ticks; LFSR_SEED, default 9'h1A5, non-zero reset seed.
REQ-002 SHALL have port clk, input, 1, the single system clock.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have port tick, input, 1, one-clk step pulse from the frame timer.
REQ-005 SHALL have port game_state, input, 2, game state: INIT=00, PLAY=01, FINISH=10.
REQ-006 SHALL have port box, input, 9, one-hot player cell.
REQ-007 SHALL have port warning_state, output, 9, cells currently warned.
REQ-008 SHALL have port fire_state, output, 9, cells currently burning.
REQ-009 SHALL have port gold_state, output, 9, gold cell, at most one bit set.
REQ-010 SHALL have port hit, output, 1, one-clk pulse when the player is burned.
REQ-011 SHALL have port collect, output, 1, one-clk pulse when the player takes gold.

Function
REQ-012 SHALL implement the FSM states IDLE, WARN, FIRE and GAP.
REQ-013 In IDLE: when game_state==PLAY, on the next clk latch pattern, go to WARN, and load the tick counter to 0.
REQ-014 In WARN: warning_state=pattern; after WARN_TICKS tick pulses, go to FIRE.
REQ-015 In FIRE: fire_state=pattern; after FIRE_TICKS tick pulses, go to GAP.
REQ-016 In GAP: all hazard outputs are 0; after GAP_TICKS tick pulses, latch a new pattern and go to WARN.
REQ-017 The counter SHALL advance only on tick; a tick on the clock of a state entry counts toward that state.
REQ-018 The 9-bit Fibonacci LFSR (x^9+x^5+1) SHALL advance every clk, including outside PLAY.
REQ-019 Pattern equals the LFSR value, with two fixes: if the value is 9'h1FF, clear bit 4 so at least one safe cell remains; if the value is 0, use 9'h001.
REQ-020 hit SHALL pulse exactly once per FIRE visit, on the first clk in FIRE where (box & fire_state)!=0.
REQ-021 When game_state leaves PLAY, on the next clk the FSM SHALL go to IDLE and all outputs, including any pending pulse, SHALL be 0.
REQ-022 All outputs SHALL be registered; latency from a state change to its outputs is 1 clk.

Reset
REQ-023 On a rst=0 clk edge: FSM=IDLE, counter=0, LFSR=LFSR_SEED, and all outputs=0, including mid-round.
REQ-024 Reset SHALL take priority over tick and over game_state.

Configuration
REQ-025 With HAZARD_GOLD_EN defined:
  - on entry to WARN, place gold at the first clear pattern bit, searching upward with wrap from index LFSR[3:0] mod 9;
  - gold persists through WARN/FIRE/GAP until collected or the next pattern latch.
REQ-026 With HAZARD_GOLD_EN defined: when (box & gold_state)!=0, pulse collect for 1 clk and clear gold_state on the same edge.
REQ-027 With HAZARD_GOLD_EN defined: a hit and a collect on the same clk SHALL both pulse.
REQ-028 Without HAZARD_GOLD_EN, gold_state and collect SHALL be constant 0 and no gold logic SHALL be synthesized.

Structure
REQ-029 The shared game package SHALL hold the game_state encodings (INIT/PLAY/FINISH), the FSM state enum, CELLS=9, and the LFSR tap constants.
REQ-030 The LFSR plus pattern sanitising SHALL be one sub-module, hazard_lfsr, whose outputs are pattern[8:0] and rnd[3:0].

Verification
REQ-031 Reset then PLAY with tick every 4 clk -> WARN/FIRE/GAP last 3/2/1 ticks; the first pattern is derived from 9'h1A5 after the IDLE->WARN latch.
REQ-032 Force the LFSR to 9'h1FF at a latch -> pattern = 9'h1EF; cell 4 is never in fire_state.
REQ-033 box=9'h010 with pattern bit 4 set -> exactly one hit pulse per FIRE visit; with bit 4 clear, none.
REQ-034 With HAZARD_GOLD_EN, move box onto the gold cell during FIRE -> collect for 1 clk, gold_state=0 on the next clk, and the gold bit never overlaps pattern.
REQ-035 game_state PLAY->FINISH mid-FIRE -> IDLE and all outputs 0 on the next clk; return to PLAY -> a new WARN round.
REQ-036 rst=0 asserted mid-WARN with tick high -> outputs 0 on the next edge and the LFSR reloads 9'h1A5.

Source files
------------

// File: rtl/hazard_scheduler_pkg.sv
// rtl/hazard_scheduler_pkg.sv - shared game encodings, FSM states, LFSR constants and pattern helpers
package hazard_scheduler_pkg;

    localparam int CELLS = 9;

    localparam logic [1:0] GS_INIT   = 2'b00;
    localparam logic [1:0] GS_PLAY   = 2'b01;
    localparam logic [1:0] GS_FINISH = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARN = 2'd1,
        FIRE = 2'd2,
        GAP  = 2'd3
    } hz_state_t;

    // x^9 + x^5 + 1: feedback from bits 8 and 4
    localparam logic [8:0] LFSR_TAPS     = 9'h110;
    localparam logic [8:0] LFSR_ALL_ONES = 9'h1FF;
    localparam logic [8:0] SAFE_CELL     = 9'h010;

    // An all-burning board would be unwinnable, so cell 4 is always kept safe then
    function automatic logic [8:0] sanitize_pattern(input logic [8:0] v);
        if (v == LFSR_ALL_ONES) return v & ~SAFE_CELL;
        if (v == 9'h000) return 9'h001;
        return v;
    endfunction

    // First clear pattern cell at or above rnd mod 9, wrapping round the board
    function automatic logic [8:0] gold_pick(input logic [8:0] pat, input logic [3:0] rnd);
        logic [8:0] g;
        logic [3:0] idx;
        logic       found;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < CELLS; k++) begin
            idx = 4'((int'(rnd) + k) % CELLS);
            if (!found && !pat[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/hazard_lfsr.sv
// rtl/hazard_lfsr.sv - free-running 9-bit Fibonacci LFSR with sanitised hazard pattern
module hazard_lfsr
    import hazard_scheduler_pkg::*;
#(
    parameter logic [8:0] SEED = 9'h1A5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [8:0] pattern,
    output logic [3:0] rnd
);

    logic [8:0] lfsr;

    // Shift every clock regardless of game state so rounds are not replayable
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[7:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign pattern = sanitize_pattern(lfsr);
    assign rnd     = lfsr[3:0];

endmodule

// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - warn/fire/gap hazard round scheduler; HAZARD_GOLD_EN adds gold pickup
module hazard_scheduler
    import hazard_scheduler_pkg::*;
#(
    parameter int         WARN_TICKS = 3,
    parameter int         FIRE_TICKS = 2,
    parameter int         GAP_TICKS  = 1,
    parameter logic [8:0] LFSR_SEED  = 9'h1A5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [1:0] game_state,
    input  logic [8:0] box,
    output logic [8:0] warning_state,
    output logic [8:0] fire_state,
    output logic [8:0] gold_state,
    output logic       hit,
    output logic       collect
);

    localparam logic [7:0] WARN_LAST = 8'(WARN_TICKS - 1);
    localparam logic [7:0] FIRE_LAST = 8'(FIRE_TICKS - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_TICKS - 1);

    hz_state_t  state, state_d;
    logic [7:0] cnt, cnt_d;
    logic [8:0] pat_q, pat_d;
    logic       latch;
    logic       hit_done, hit_done_d, hit_d;
    logic [8:0] warn_d, fire_d;
    logic [8:0] pattern;
    logic [3:0] rnd;

    hazard_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .pattern (pattern),
        .rnd     (rnd)
    );

    // Next state; the counter starts at 0 on entry and only counts ticks seen inside the state
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        latch   = 1'b0;
        if (game_state != GS_PLAY) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: latch = 1'b1;
                WARN: if (tick) begin
                    if (cnt == WARN_LAST) begin
                        state_d = FIRE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 8'd1;
                    end
                end
                FIRE: if (tick) begin
                    if (cnt == FIRE_LAST) begin
                        state_d = GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 8'd1;
                    end
                end
                GAP: if (tick) begin
                    if (cnt == GAP_LAST) begin
                        latch = 1'b1;
                    end else begin
                        cnt_d = cnt + 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (latch) begin
                state_d = WARN;
                cnt_d   = '0;
            end
        end
        pat_d      = latch ? pattern : pat_q;
        hit_d      = (game_state == GS_PLAY) && (state == FIRE) && !hit_done && (|(box & fire_state));
        hit_done_d = (state_d == FIRE) && (hit_done || hit_d);
        warn_d     = (state_d == WARN) ? pat_d : 9'h000;
        fire_d     = (state_d == FIRE) ? pat_d : 9'h000;
    end

    // State and registered hazard outputs, aligned with the state they describe
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            pat_q         <= '0;
            hit_done      <= 1'b0;
            warning_state <= '0;
            fire_state    <= '0;
            hit           <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            pat_q         <= pat_d;
            hit_done      <= hit_done_d;
            warning_state <= warn_d;
            fire_state    <= fire_d;
            hit           <= hit_d;
        end
    end

`ifdef HAZARD_GOLD_EN
    logic [8:0] gold_d;
    logic       collect_d;

    // Gold is placed on a safe cell at each latch and removed when the player steps on it
    always_comb begin
        collect_d = (game_state == GS_PLAY) && (|(box & gold_state));
        gold_d    = gold_state;
        if (collect_d) gold_d = '0;
        if (latch) gold_d = gold_pick(pattern, rnd);
        if (game_state != GS_PLAY) gold_d = '0;
    end

    // Gold output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            gold_state <= '0;
            collect    <= 1'b0;
        end else begin
            gold_state <= gold_d;
            collect    <= collect_d;
        end
    end
`else
    logic unused_rnd;
    assign unused_rnd = ^rnd;
    assign gold_state = '0;
    assign collect    = 1'b0;
`endif

endmodule
